// File: rtl/shift_reg_n_pkg.sv
// Shared types for the shift_reg_n register slice: operation mode encoding.
// Optional parity output of the top is controlled by SHIFT_REG_PARITY_EN.
package shift_reg_pkg;

   localparam int MODE_W = 3;

   typedef enum logic [MODE_W-1:0] {
      MODE_HOLD = 3'b000,
      MODE_LOAD = 3'b001,
      MODE_SHL  = 3'b010,
      MODE_SHR  = 3'b011,
      MODE_ROTL = 3'b100,
      MODE_ROTR = 3'b101,
      MODE_ASHR = 3'b110,
      MODE_CLR  = 3'b111
   } mode_e;

   function automatic logic is_shift_mode(input mode_e m);
      return (m == MODE_SHL) || (m == MODE_SHR) || (m == MODE_ROTL) ||
             (m == MODE_ROTR) || (m == MODE_ASHR);
   endfunction

endpackage

// File: rtl/shift_reg_n_sat_counter.sv
// Saturating up-counter with synchronous clear; at_max flags count == MAX.
// Clear takes priority over increment; the count never wraps.
module sat_counter #(
   parameter int CNT_W = 4,
   parameter int MAX   = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] count,
   output logic             at_max
);

   localparam logic [CNT_W-1:0] MaxVal = CNT_W'(MAX);

   logic [CNT_W-1:0] count_d, count_q;

   always_comb begin
      count_d = count_q;
      if (clr) begin
         count_d = '0;
      end else if (inc && (count_q != MaxVal)) begin
         count_d = count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count  = count_q;
   assign at_max = (count_q == MaxVal);

endmodule

// File: rtl/shift_reg_n.sv
// WIDTH-bit mode-selected shift/rotate/load register with saturating shift counter.
// Define SHIFT_REG_PARITY_EN to add a registered parity output of the register.
module shift_reg_n
   import shift_reg_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int CNT_W = $clog2(WIDTH + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [MODE_W-1:0] mode,
   input  logic [WIDTH-1:0]  din,
   input  logic              sin,
   input  logic              count_clr,
   output logic [WIDTH-1:0]  dout,
   output logic              sout,
   output logic [CNT_W-1:0]  shift_cnt,
`ifdef SHIFT_REG_PARITY_EN
   output logic              parity,
`endif
   output logic              done
);

   mode_e            mode_s;
   logic [WIDTH-1:0] dout_d, dout_q;
   logic             sout_d, sout_q;
   logic             cnt_inc, cnt_clr;

   assign mode_s = mode_e'(mode);

   // sin is only consumed by SHL/SHR, so an undriven sin cannot leak into other modes.
   always_comb begin
      dout_d = dout_q;
      sout_d = sout_q;
      unique case (mode_s)
         MODE_HOLD: ;
         MODE_LOAD: dout_d = din;
         MODE_SHL: begin
            dout_d = {dout_q[WIDTH-2:0], sin};
            sout_d = dout_q[WIDTH-1];
         end
         MODE_SHR: begin
            dout_d = {sin, dout_q[WIDTH-1:1]};
            sout_d = dout_q[0];
         end
         MODE_ROTL: begin
            dout_d = {dout_q[WIDTH-2:0], dout_q[WIDTH-1]};
            sout_d = dout_q[WIDTH-1];
         end
         MODE_ROTR: begin
            dout_d = {dout_q[0], dout_q[WIDTH-1:1]};
            sout_d = dout_q[0];
         end
         MODE_ASHR: begin
            dout_d = {dout_q[WIDTH-1], dout_q[WIDTH-1:1]};
            sout_d = dout_q[0];
         end
         MODE_CLR: begin
            dout_d = '0;
            sout_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         dout_q <= '0;
         sout_q <= 1'b0;
      end else begin
         dout_q <= dout_d;
         sout_q <= sout_d;
      end
   end

   assign cnt_inc = is_shift_mode(mode_s);
   assign cnt_clr = count_clr || (mode_s == MODE_LOAD) || (mode_s == MODE_CLR);

   sat_counter #(
      .CNT_W (CNT_W),
      .MAX   (WIDTH)
   ) u_sat_counter (
      .clk    (clk),
      .rst    (rst),
      .inc    (cnt_inc),
      .clr    (cnt_clr),
      .count  (shift_cnt),
      .at_max (done)
   );

`ifdef SHIFT_REG_PARITY_EN
   logic parity_d, parity_q;

   assign parity_d = ^dout_d;

   always_ff @(posedge clk) begin
      if (!rst) begin
         parity_q <= 1'b0;
      end else begin
         parity_q <= parity_d;
      end
   end

   assign parity = parity_q;
`endif

   assign dout = dout_q;
   assign sout = sout_q;

endmodule
